// File: rtl/room_scene_pkg.sv
// rtl/room_scene_pkg.sv - scene object types, speed states and default object table
package room_scene_pkg;

   typedef enum logic [1:0] {
      WINDOW = 2'd0,
      DOOR   = 2'd1,
      CORNER = 2'd2
   } obj_kind_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SLOW = 2'd1,
      FAST = 2'd2
   } speed_state_e;

   localparam int OBJ_XW      = 12;
   localparam int NUM_OBJ_DEF = 6;

   // Corners ignore half_w and the y range; their shape is a seam plus a floor wedge.
   typedef struct packed {
      obj_kind_e         kind;
      logic [OBJ_XW-1:0] world_x;
      logic [9:0]        half_w;
      logic [9:0]        y_top;
      logic [9:0]        y_bot;
   } obj_t;

   localparam obj_t [0:NUM_OBJ_DEF-1] OBJ_TABLE = '{
      '{WINDOW, 12'd640,  10'd160, 10'd100, 10'd300},
      '{DOOR,   12'd1280, 10'd80,  10'd100, 10'd480},
      '{CORNER, 12'd320,  10'd0,   10'd0,   10'd0},
      '{CORNER, 12'd960,  10'd0,   10'd0,   10'd0},
      '{CORNER, 12'd1600, 10'd0,   10'd0,   10'd0},
      '{CORNER, 12'd2240, 10'd0,   10'd0,   10'd0}
   };

endpackage

// File: rtl/room_scroll_engine_if.sv
// rtl/room_scroll_engine_if.sv - pixel, scroll and hit-mask signals of the scroll engine
interface room_scroll_engine_if #(
   parameter int NUM_OBJ = 6,
   parameter int CW      = 12
);
   logic               frame_tick;
   logic               video_on;
   logic [9:0]         x;
   logic [9:0]         y;
   logic               shift_r;
   logic               shift_l;
   logic [CW-1:0]      cam_x;
   logic [NUM_OBJ-1:0] obj_hit;
   logic               window;
   logic               door;
   logic               corner;
   logic               fast;

   modport master (
      output frame_tick, video_on, x, y, shift_r, shift_l,
      input  cam_x, obj_hit, window, door, corner, fast
   );

   modport slave (
      input  frame_tick, video_on, x, y, shift_r, shift_l,
      output cam_x, obj_hit, window, door, corner, fast
   );
endinterface

// File: rtl/room_obj_hit.sv
// rtl/room_obj_hit.sv - combinational hit test of one scene object against a pixel
module room_obj_hit
   import room_scene_pkg::*;
#(
   parameter int CW      = 12,
   parameter int WORLD_W = 2560,
   parameter int FLOOR_Y = 440
) (
   input  obj_t          obj,
   input  logic [CW-1:0] cam_x,
   input  logic [9:0]    x,
   input  logic [9:0]    y,
   input  logic          video_on,
   output logic          hit
);
   // Wide signed arithmetic so off-screen (negative) positions compare correctly.
   localparam int SW = CW + 4;
   localparam logic signed [SW-1:0] WS   = SW'(WORLD_W);
   localparam logic signed [SW-1:0] HS   = SW'(WORLD_W / 2);
   localparam logic signed [SW-1:0] FY   = SW'(FLOOR_Y);
   localparam logic signed [SW-1:0] SEAM = SW'(2);

   logic signed [SW-1:0] d, xs, ys, half, dx, dy4;
   logic box, seam, wedge;

   // Screen position of the object relative to the camera, taken the short way round the world.
   always_comb begin
      d = signed'(SW'(obj.world_x)) - signed'(SW'(cam_x));
      if (d < 0)
         d = d + WS;
      if (d >= HS)
         d = d - WS;
      xs    = signed'(SW'(x));
      ys    = signed'(SW'(y));
      half  = signed'(SW'(obj.half_w));
      box   = (xs >= d - half) && (xs < d + half) && (y >= obj.y_top) && (y < obj.y_bot);
      seam  = (xs >= d - SEAM) && (xs <= d);
      dx    = xs - d;
      if (dx < 0)
         dx = -dx;
      dy4   = (ys - FY) <<< 2;
      wedge = (ys >= FY) && (dx <= dy4);
      hit   = video_on && ((obj.kind == CORNER) ? (seam || wedge) : box);
   end

endmodule

// File: rtl/room_scroll_engine.sv
// rtl/room_scroll_engine.sv - frame-synchronous camera scroller with per-object hit masks
module room_scroll_engine
   import room_scene_pkg::*;
#(
   parameter int NUM_OBJ     = 6,
   parameter int CW          = 12,
   parameter int WORLD_W     = 2560,
   parameter int H_ACTIVE    = 640,
   parameter int STEP        = 8,
   parameter int HOLD_FRAMES = 16,
   parameter int WRAP        = 1,
   parameter int FLOOR_Y     = 440,
   parameter obj_t [0:NUM_OBJ-1] OBJ = OBJ_TABLE
) (
   input logic                 clk_100MHz,
   input logic                 rst_n,
   room_scroll_engine_if.slave bus
);
   localparam int HW = $clog2(HOLD_FRAMES + 1);
   localparam logic [CW:0]   WORLD     = (CW+1)'(WORLD_W);
   localparam logic [CW:0]   CAM_MAX   = (CW+1)'(WORLD_W - H_ACTIVE);
   localparam logic [CW:0]   MOVE_SLOW = (CW+1)'(STEP);
   localparam logic [CW:0]   MOVE_FAST = (CW+1)'(2 * STEP);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_FRAMES);

   speed_state_e  state;
   logic          dir;
   logic [HW-1:0] hold_cnt;
   logic [CW-1:0] cam_x_q;
   logic          fast_q;

   // Camera after one move; wraps round the world or pins to the last full screen.
   function automatic logic [CW-1:0] next_cam(input logic [CW-1:0] cam,
                                              input logic right,
                                              input logic [CW:0] move);
      logic [CW:0] c, r;
      c = {1'b0, cam};
      if (right) begin
         r = c + move;
         if (WRAP != 0) begin
            if (r >= WORLD)
               r = r - WORLD;
         end else if (r > CAM_MAX) begin
            r = CAM_MAX;
         end
      end else begin
         if (c >= move)
            r = c - move;
         else if (WRAP != 0)
            r = c + WORLD - move;
         else
            r = '0;
      end
      return r[CW-1:0];
   endfunction

   // Speed FSM and camera; only a frame tick may change them so a frame never tears.
   always_ff @(posedge clk_100MHz) begin
      if (!rst_n) begin
         state    <= IDLE;
         dir      <= 1'b0;
         hold_cnt <= '0;
         cam_x_q  <= '0;
         fast_q   <= 1'b0;
      end else if (bus.frame_tick) begin
         if (bus.shift_r == bus.shift_l) begin
            state    <= IDLE;
            hold_cnt <= '0;
            fast_q   <= 1'b0;
         end else if (state == IDLE || bus.shift_r != dir) begin
            state    <= SLOW;
            dir      <= bus.shift_r;
            hold_cnt <= HW'(1);
            fast_q   <= 1'b0;
            cam_x_q  <= next_cam(cam_x_q, bus.shift_r, MOVE_SLOW);
         end else if (state == SLOW) begin
            if (hold_cnt != HOLD_MAX)
               hold_cnt <= hold_cnt + HW'(1);
            cam_x_q <= next_cam(cam_x_q, bus.shift_r, MOVE_SLOW);
            if (hold_cnt >= HOLD_LAST) begin
               state  <= FAST;
               fast_q <= 1'b1;
            end
         end else begin
            cam_x_q <= next_cam(cam_x_q, bus.shift_r, MOVE_FAST);
         end
      end
   end

   logic [NUM_OBJ-1:0] hit_c, win_m, door_m, corner_m;
   logic [NUM_OBJ-1:0] obj_hit_q;
   logic               window_q, door_q, corner_q;

   for (genvar gi = 0; gi < NUM_OBJ; gi++) begin : g_obj
      room_obj_hit #(
         .CW      (CW),
         .WORLD_W (WORLD_W),
         .FLOOR_Y (FLOOR_Y)
      ) u_hit (
         .obj      (OBJ[gi]),
         .cam_x    (cam_x_q),
         .x        (bus.x),
         .y        (bus.y),
         .video_on (bus.video_on),
         .hit      (hit_c[gi])
      );
      assign win_m[gi]    = (OBJ[gi].kind == WINDOW);
      assign door_m[gi]   = (OBJ[gi].kind == DOOR);
      assign corner_m[gi] = (OBJ[gi].kind == CORNER);
   end

   // Register per-object hits and the per-class masks for the colour mux.
   always_ff @(posedge clk_100MHz) begin
      if (!rst_n) begin
         obj_hit_q <= '0;
         window_q  <= 1'b0;
         door_q    <= 1'b0;
         corner_q  <= 1'b0;
      end else begin
         obj_hit_q <= hit_c;
         window_q  <= |(hit_c & win_m);
         door_q    <= |(hit_c & door_m);
         corner_q  <= |(hit_c & corner_m);
      end
   end

   assign bus.cam_x   = cam_x_q;
   assign bus.fast    = fast_q;
   assign bus.obj_hit = obj_hit_q;
   assign bus.window  = window_q;
   assign bus.door    = door_q;
   assign bus.corner  = corner_q;

endmodule
